// File: rtl/dwt_pkg.sv
// -----------------------------------------------------------------------------
// dwt_pkg
// Shared constants, types and helpers for the LeGall 5/3 lifting engine.
//   WIDTH / HEIGHT : default image dimensions in pixels
//   PIX_W          : pixel width
//   D_W / A_W      : signed widths of the detail and approximation terms
//   DC_OFFSET      : bias that maps a signed detail into the unsigned output range
//   line_mode_t    : ROW lines are WIDTH pixels long, COL lines are HEIGHT pixels long
//   clamp_u8       : saturate a signed value into 0..255
// -----------------------------------------------------------------------------
package dwt_pkg;

  localparam int WIDTH     = 512;
  localparam int HEIGHT    = 512;
  localparam int PIX_W     = 8;
  localparam int D_W       = 10;
  localparam int A_W       = 11;
  localparam int DC_OFFSET = 128;

  typedef enum logic {
    ROW = 1'b0,
    COL = 1'b1
  } line_mode_t;

  function automatic logic [PIX_W-1:0] clamp_u8(input logic signed [A_W-1:0] v);
    logic [PIX_W-1:0] r;
    if (v < 11'sd0) begin
      r = 8'd0;
    end else if (v > 11'sd255) begin
      r = 8'd255;
    end else begin
      r = v[PIX_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/dwt53_line_ctrl.sv
// -----------------------------------------------------------------------------
// dwt53_line_ctrl
// Line sequencing for the 5/3 lifting engine: pair counter, per-mode line
// length, abort detection, end-of-line flush and the o_err pulse.
// The tag registers here are the tags of the pair currently held in H.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   i_valid           : a pixel pair is being sampled this cycle
//   i_mode, i_rc      : tags of the incoming pair
//   o_first           : incoming pair is k = 0 of its line (new line or abort)
//   o_release         : the pair in H moves into the predict stage this cycle
//   o_release_last    : the released pair is the last of its line (flush)
//   o_tag_mode/o_tag_rc : tags of the pair held in H
//   o_err             : registered one-cycle abort pulse
// -----------------------------------------------------------------------------
module dwt53_line_ctrl #(
  parameter int WIDTH  = 512,
  parameter int HEIGHT = 512,
  parameter int RC_W   = $clog2(WIDTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid,
  input  logic            i_mode,
  input  logic [RC_W-1:0] i_rc,
  output logic            o_first,
  output logic            o_release,
  output logic            o_release_last,
  output logic            o_tag_mode,
  output logic [RC_W-1:0] o_tag_rc,
  output logic            o_err
);
  import dwt_pkg::*;

  localparam int MAX_DIM = (WIDTH > HEIGHT) ? WIDTH : HEIGHT;
  localparam int K_W     = $clog2(MAX_DIM);
  localparam logic [K_W-1:0] ROW_LAST_K = K_W'(WIDTH / 2 - 1);
  localparam logic [K_W-1:0] COL_LAST_K = K_W'(HEIGHT / 2 - 1);
  localparam logic [K_W-1:0] K_ZERO     = {K_W{1'b0}};
  localparam logic [K_W-1:0] K_ONE      = K_W'(1'b1);

  logic [K_W-1:0]  r_k;
  logic            r_flush;
  logic            r_tag_mode;
  logic [RC_W-1:0] r_tag_rc;
  logic            r_err;

  line_mode_t      w_mode;
  logic [K_W-1:0]  w_last_k;
  logic [K_W-1:0]  w_k_eff;
  logic            w_abort;
  logic            w_is_last;

  assign w_mode = line_mode_t'(i_mode);

  // Index of the last pair for the incoming pair's line type
  always_comb begin
    w_last_k = ROW_LAST_K;
    case (w_mode)
      ROW:     w_last_k = ROW_LAST_K;
      COL:     w_last_k = COL_LAST_K;
      default: w_last_k = ROW_LAST_K;
    endcase
  end

  // A mid-line pair whose tags disagree with H restarts as pair 0 of its own line
  assign w_abort   = i_valid && (r_k != K_ZERO) &&
                     ((i_mode != r_tag_mode) || (i_rc != r_tag_rc));
  assign w_k_eff   = w_abort ? K_ZERO : r_k;
  assign w_is_last = (w_k_eff == w_last_k);

  // Counter, flush flag, H tags and abort pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_k        <= K_ZERO;
      r_flush    <= 1'b0;
      r_tag_mode <= 1'b0;
      r_tag_rc   <= {RC_W{1'b0}};
      r_err      <= 1'b0;
    end else begin
      r_err   <= w_abort;
      // The flush lasts exactly one cycle: the next sampled pair is k = 0 and never last
      r_flush <= i_valid && w_is_last;
      if (i_valid) begin
        r_k        <= w_is_last ? K_ZERO : (w_k_eff + K_ONE);
        r_tag_mode <= i_mode;
        r_tag_rc   <= i_rc;
      end
    end
  end

  assign o_first        = (r_k == K_ZERO) || w_abort;
  // Incoming pair k >= 1 supplies e_{k} for the pair in H; the flush supplies its own mirror
  assign o_release      = (i_valid && (r_k != K_ZERO) && !w_abort) || r_flush;
  assign o_release_last = r_flush;
  assign o_tag_mode     = r_tag_mode;
  assign o_tag_rc       = r_tag_rc;
  assign o_err          = r_err;

endmodule

// File: rtl/dwt53_mac.sv
// -----------------------------------------------------------------------------
// dwt53_mac
// Reversible LeGall 5/3 lifting engine, one even/odd pixel pair per cycle.
// Datapath: H holds the newest pair; P loads the released pair with its right
// neighbour e_{k+1}, then registers d_k alongside d_{k-1}; U forms a_k,
// saturates both coefficients and drives the registered outputs.
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   i_pix               : [15:8] even pixel, [7:0] odd pixel
//   i_pix_valid         : pair present
//   i_pix_mode          : 0 row line, 1 column line
//   i_pix_row_column    : line index
//   o_coef              : [15:8] clamp(a), [7:0] clamp(d + 128)
//   o_coef_valid        : coefficient pair valid
//   o_coef_mode         : mode of emitted pair
//   o_coef_row_column   : line index of emitted pair
//   o_line_done         : pulse with the last pair of a line
//   o_err               : pulse on line abort
// -----------------------------------------------------------------------------
module dwt53_mac #(
  parameter int WIDTH  = dwt_pkg::WIDTH,
  parameter int HEIGHT = dwt_pkg::HEIGHT,
  parameter int RC_W   = $clog2(WIDTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [15:0]     i_pix,
  input  logic            i_pix_valid,
  input  logic            i_pix_mode,
  input  logic [RC_W-1:0] i_pix_row_column,
  output logic [15:0]     o_coef,
  output logic            o_coef_valid,
  output logic            o_coef_mode,
  output logic [RC_W-1:0] o_coef_row_column,
  output logic            o_line_done,
  output logic            o_err
);
  import dwt_pkg::*;

  logic            w_first;
  logic            w_release;
  logic            w_release_last;
  logic            w_tag_mode;
  logic [RC_W-1:0] w_tag_rc;

  dwt53_line_ctrl #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .RC_W   (RC_W)
  ) u_ctrl (
    .clk            (clk),
    .rst            (rst),
    .i_valid        (i_pix_valid),
    .i_mode         (i_pix_mode),
    .i_rc           (i_pix_row_column),
    .o_first        (w_first),
    .o_release      (w_release),
    .o_release_last (w_release_last),
    .o_tag_mode     (w_tag_mode),
    .o_tag_rc       (w_tag_rc),
    .o_err          (o_err)
  );

  // ---------------- H: holding register ----------------
  logic [PIX_W-1:0] r_h_e;
  logic [PIX_W-1:0] r_h_o;
  logic             r_h_first;

  // Capture every sampled pair; tags live in the line controller
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_h_e     <= 8'd0;
      r_h_o     <= 8'd0;
      r_h_first <= 1'b0;
    end else if (i_pix_valid) begin
      r_h_e     <= i_pix[15:8];
      r_h_o     <= i_pix[7:0];
      r_h_first <= w_first;
    end
  end

  // ---------------- P: released pair with its right neighbour ----------------
  logic             r_p_vld;
  logic [PIX_W-1:0] r_p_e;
  logic [PIX_W-1:0] r_p_o;
  logic [PIX_W-1:0] r_p_en;
  logic             r_p_first;
  logic             r_p_last;
  logic             r_p_mode;
  logic [RC_W-1:0]  r_p_rc;

  // Load the released pair; at line end the even neighbour mirrors onto itself
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_p_vld   <= 1'b0;
      r_p_e     <= 8'd0;
      r_p_o     <= 8'd0;
      r_p_en    <= 8'd0;
      r_p_first <= 1'b0;
      r_p_last  <= 1'b0;
      r_p_mode  <= 1'b0;
      r_p_rc    <= {RC_W{1'b0}};
    end else begin
      r_p_vld <= w_release;
      if (w_release) begin
        r_p_e     <= r_h_e;
        r_p_o     <= r_h_o;
        r_p_en    <= w_release_last ? r_h_e : i_pix[15:8];
        r_p_first <= r_h_first;
        r_p_last  <= w_release_last;
        r_p_mode  <= w_tag_mode;
        r_p_rc    <= w_tag_rc;
      end
    end
  end

  // Predict: d = o - floor((e + e_next) / 2)
  logic [PIX_W:0]         w_pair_sum;
  logic [D_W-1:0]         w_half;
  logic signed [D_W-1:0]  w_d;

  assign w_pair_sum = {1'b0, r_p_e} + {1'b0, r_p_en};
  assign w_half     = {1'b0, w_pair_sum} >> 1'b1;
  assign w_d        = $signed({2'b00, r_p_o}) - $signed(w_half);

  logic                   r_q_vld;
  logic signed [D_W-1:0]  r_q_d;
  logic signed [D_W-1:0]  r_q_dprev;
  logic [PIX_W-1:0]       r_q_e;
  logic                   r_q_last;
  logic                   r_q_mode;
  logic [RC_W-1:0]        r_q_rc;

  // Register d_k next to d_{k-1}; r_q_d doubles as the per-line detail history
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q_vld   <= 1'b0;
      r_q_d     <= 10'sd0;
      r_q_dprev <= 10'sd0;
      r_q_e     <= 8'd0;
      r_q_last  <= 1'b0;
      r_q_mode  <= 1'b0;
      r_q_rc    <= {RC_W{1'b0}};
    end else begin
      r_q_vld <= r_p_vld;
      if (r_p_vld) begin
        r_q_d     <= w_d;
        // Pair 0 has no left detail: mirror d_0 into d_{-1}
        r_q_dprev <= r_p_first ? w_d : r_q_d;
        r_q_e     <= r_p_e;
        r_q_last  <= r_p_last;
        r_q_mode  <= r_p_mode;
        r_q_rc    <= r_p_rc;
      end
    end
  end

  // ---------------- U: update, saturate, output ----------------
  logic signed [A_W-1:0] w_d_ext;
  logic signed [A_W-1:0] w_dprev_ext;
  logic signed [A_W-1:0] w_upd_sum;
  logic signed [A_W-1:0] w_a;
  logic signed [A_W-1:0] w_d_off;

  assign w_d_ext     = {r_q_d[D_W-1], r_q_d};
  assign w_dprev_ext = {r_q_dprev[D_W-1], r_q_dprev};
  assign w_upd_sum   = w_dprev_ext + w_d_ext + 11'sd2;
  // Arithmetic shift floors negative update terms, keeping the transform reversible
  assign w_a         = $signed({3'b000, r_q_e}) + (w_upd_sum >>> 2'd2);
  assign w_d_off     = w_d_ext + $signed(A_W'(DC_OFFSET));

  logic [15:0]     r_coef;
  logic            r_coef_valid;
  logic            r_coef_mode;
  logic [RC_W-1:0] r_coef_rc;
  logic            r_line_done;

  // Output registers; data holds between valid cycles, pulses do not
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_coef       <= 16'd0;
      r_coef_valid <= 1'b0;
      r_coef_mode  <= 1'b0;
      r_coef_rc    <= {RC_W{1'b0}};
      r_line_done  <= 1'b0;
    end else begin
      r_coef_valid <= r_q_vld;
      r_line_done  <= r_q_vld && r_q_last;
      if (r_q_vld) begin
        r_coef      <= {clamp_u8(w_a), clamp_u8(w_d_off)};
        r_coef_mode <= r_q_mode;
        r_coef_rc   <= r_q_rc;
      end
    end
  end

  assign o_coef            = r_coef;
  assign o_coef_valid      = r_coef_valid;
  assign o_coef_mode       = r_coef_mode;
  assign o_coef_row_column = r_coef_rc;
  assign o_line_done       = r_line_done;

endmodule

// File: tb/tb_dwt53_mac.sv
// -----------------------------------------------------------------------------
// tb_dwt53_mac
// Scoreboard bench for dwt53_mac with WIDTH = HEIGHT = 8. The reference model
// buffers each line's pixels and evaluates the 5/3 formulas directly; expected
// pairs are queued as soon as their right neighbour is known and a negedge
// monitor pops and compares every valid output.
// -----------------------------------------------------------------------------
module tb_dwt53_mac;

  localparam int WIDTH  = 8;
  localparam int HEIGHT = 8;
  localparam int RC_W   = 3;
  localparam int LR     = WIDTH / 2;
  localparam int LC     = HEIGHT / 2;
  localparam logic [15:0] RAMP [4] = '{16'h0080, 16'h0280, 16'h0480, 16'h0681};

  logic            clk = 1'b0;
  logic            rst;
  logic [15:0]     i_pix;
  logic            i_pix_valid;
  logic            i_pix_mode;
  logic [RC_W-1:0] i_pix_row_column;
  logic [15:0]     o_coef;
  logic            o_coef_valid;
  logic            o_coef_mode;
  logic [RC_W-1:0] o_coef_row_column;
  logic            o_line_done;
  logic            o_err;

  always #5 clk = ~clk;

  dwt53_mac #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .RC_W(RC_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .i_pix             (i_pix),
    .i_pix_valid       (i_pix_valid),
    .i_pix_mode        (i_pix_mode),
    .i_pix_row_column  (i_pix_row_column),
    .o_coef            (o_coef),
    .o_coef_valid      (o_coef_valid),
    .o_coef_mode       (o_coef_mode),
    .o_coef_row_column (o_coef_row_column),
    .o_line_done       (o_line_done),
    .o_err             (o_err)
  );

  typedef struct {
    logic [15:0]     coef;
    logic            mode;
    logic [RC_W-1:0] rc;
    logic            done;
  } exp_t;

  exp_t        exp_q[$];
  int          exp_err_q[$];
  int          obs_cyc[$];
  logic [15:0] obs_coef[$];
  int          err_seen = 0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  // reference line buffer
  int              be[8];
  int              bo[8];
  int              buf_n = 0;
  int              buf_len = LR;
  logic            buf_mode = 1'b0;
  logic [RC_W-1:0] buf_rc = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input int act, input int req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic int clamp8(input int v);
    return (v < 0) ? 0 : ((v > 255) ? 255 : v);
  endfunction

  // d_k = o_k - floor((e_k + e_{k+1}) / 2), with e_L mirrored to e_{L-1}
  function automatic int d_of(input int k);
    int en;
    en = (k == buf_len - 1) ? be[k] : be[k + 1];
    return bo[k] - ((be[k] + en) / 2);
  endfunction

  function automatic void push_exp(input int k);
    int dk, dm, a;
    exp_t x;
    dk = d_of(k);
    dm = (k == 0) ? dk : d_of(k - 1);
    a  = be[k] + ((dm + dk + 2) >>> 2);
    x.coef = 16'(clamp8(a) * 256 + clamp8(dk + 128));
    x.mode = buf_mode;
    x.rc   = buf_rc;
    x.done = (k == buf_len - 1);
    exp_q.push_back(x);
  endfunction

  function automatic void model_accept(input logic [7:0] e, input logic [7:0] o,
                                       input logic m, input logic [RC_W-1:0] rc);
    if (buf_n != 0 && (m != buf_mode || rc != buf_rc)) begin
      exp_err_q.push_back(cyc + 1);
      buf_n = 0;
    end
    if (buf_n == 0) begin
      buf_mode = m;
      buf_rc   = rc;
      buf_len  = m ? LC : LR;
    end
    be[buf_n] = int'(e);
    bo[buf_n] = int'(o);
    buf_n++;
    if (buf_n >= 2) push_exp(buf_n - 2);
    if (buf_n == buf_len) begin
      push_exp(buf_len - 1);
      buf_n = 0;
    end
  endfunction

  task automatic send_pair(input logic [7:0] e, input logic [7:0] o,
                           input logic m, input logic [RC_W-1:0] rc);
    model_accept(e, o, m, rc);
    i_pix            = {e, o};
    i_pix_mode       = m;
    i_pix_row_column = rc;
    i_pix_valid      = 1'b1;
    @(posedge clk); #1;
    i_pix_valid      = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain;
    int t;
    t = 0;
    while ((exp_q.size() != 0 || exp_err_q.size() != 0) && t < 30) begin
      @(posedge clk); #1;
      t++;
    end
    chk(exp_q.size() == 0, "drain_outputs_pending", exp_q.size(), 0);
    chk(exp_err_q.size() == 0, "drain_err_pending", exp_err_q.size(), 0);
    idle(2);
  endtask

  task automatic clear_obs;
    obs_cyc.delete();
    obs_coef.delete();
  endtask

  task automatic pulse_reset;
    rst         = 1'b0;
    i_pix_valid = 1'b0;
    exp_q.delete();
    exp_err_q.delete();
    buf_n = 0;
    #1;
    chk(o_coef == 16'h0 && !o_coef_valid && !o_line_done && !o_err &&
        !o_coef_mode && o_coef_row_column == '0, "reset_outputs",
        {o_err, o_line_done, o_coef_valid, o_coef_mode, o_coef_row_column, o_coef}, 0);
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  function automatic logic [7:0] rpix();
    if ($urandom_range(0, 3) == 0) return ($urandom_range(0, 1) == 1) ? 8'd255 : 8'd0;
    else return 8'($urandom);
  endfunction

  // Monitor: pop the scoreboard on every valid output and track error pulses
  always @(negedge clk) begin
    exp_t x;
    if (rst) begin
      if (o_coef_valid) begin
        obs_cyc.push_back(cyc);
        obs_coef.push_back(o_coef);
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_output", o_coef, 0);
        end else begin
          x = exp_q.pop_front();
          chk(o_coef == x.coef && o_coef_mode == x.mode &&
              o_coef_row_column == x.rc && o_line_done == x.done, "coef_pair",
              {o_line_done, o_coef_mode, o_coef_row_column, o_coef},
              {x.done, x.mode, x.rc, x.coef});
        end
      end else if (o_line_done) begin
        chk(1'b0, "line_done_without_valid", 1, 0);
      end
      if (exp_err_q.size() != 0 && exp_err_q[0] < cyc) begin
        chk(1'b0, "missed_err", cyc, exp_err_q[0]);
        void'(exp_err_q.pop_front());
      end
      if (o_err) begin
        err_seen++;
        if (exp_err_q.size() != 0 && exp_err_q[0] == cyc) begin
          chk(1'b1, "err_pulse", cyc, cyc);
          void'(exp_err_q.pop_front());
        end else begin
          chk(1'b0, "unexpected_err", cyc, (exp_err_q.size() != 0) ? exp_err_q[0] : -1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_in;
    int e0;
    rst              = 1'b1;
    i_pix            = 16'h0;
    i_pix_valid      = 1'b0;
    i_pix_mode       = 1'b0;
    i_pix_row_column = '0;
    #2;
    pulse_reset();

    // 1: ramp row 3
    clear_obs();
    t_in = cyc + 1;
    for (int i = 0; i < 4; i++) send_pair(8'(2 * i), 8'(2 * i + 1), 1'b0, 3'd3);
    drain();
    chk(obs_coef.size() == 4, "ramp_count", obs_coef.size(), 4);
    for (int i = 0; i < obs_coef.size(); i++) chk(obs_coef[i] == RAMP[i], "ramp_coef", obs_coef[i], RAMP[i]);
    if (obs_cyc.size() == 4) begin
      chk(obs_cyc[0] == t_in + 3, "ramp_first_latency", obs_cyc[0] - t_in, 3);
      chk(obs_cyc[3] == t_in + 6, "ramp_last_latency", obs_cyc[3] - t_in, 6);
    end

    // 2: constant column line
    clear_obs();
    for (int i = 0; i < 4; i++) send_pair(8'd50, 8'd50, 1'b1, 3'd5);
    drain();
    chk(obs_coef.size() == 4, "const_count", obs_coef.size(), 4);
    for (int i = 0; i < obs_coef.size(); i++) chk(obs_coef[i] == 16'h3280, "const_coef", obs_coef[i], 16'h3280);

    // 3: two rows back to back
    clear_obs();
    for (int r = 1; r <= 2; r++)
      for (int i = 0; i < 4; i++) send_pair(rpix(), rpix(), 1'b0, 3'(r));
    drain();
    chk(obs_coef.size() == 8, "two_rows_count", obs_coef.size(), 8);
    if (obs_cyc.size() == 8) chk(obs_cyc[7] - obs_cyc[0] == 7, "two_rows_contiguous", obs_cyc[7] - obs_cyc[0], 7);

    // 4: saturation
    clear_obs();
    for (int i = 0; i < 4; i++) send_pair(8'd0, 8'd255, 1'b0, 3'd0);
    drain();
    chk(obs_coef.size() == 4, "sat_count", obs_coef.size(), 4);
    for (int i = 0; i < obs_coef.size(); i++) chk(obs_coef[i] == 16'h80FF, "sat_coef", obs_coef[i], 16'h80FF);

    // 5: abort of row 1 by row 2
    clear_obs();
    e0 = err_seen;
    send_pair(8'd10, 8'd20, 1'b0, 3'd1);
    send_pair(8'd30, 8'd40, 1'b0, 3'd1);
    for (int i = 0; i < 4; i++) send_pair(8'(2 * i), 8'(2 * i + 1), 1'b0, 3'd2);
    drain();
    chk(err_seen - e0 == 1, "abort_err_count", err_seen - e0, 1);
    chk(obs_coef.size() == 5, "abort_out_count", obs_coef.size(), 5);
    if (obs_coef.size() == 5) chk(obs_coef[0] == 16'h0A80, "abort_row1_pair0", obs_coef[0], 16'h0A80);

    // 6: reset mid-line, then ramp again
    send_pair(8'd0, 8'd1, 1'b0, 3'd3);
    send_pair(8'd2, 8'd3, 1'b0, 3'd3);
    pulse_reset();
    clear_obs();
    t_in = cyc + 1;
    for (int i = 0; i < 4; i++) send_pair(8'(2 * i), 8'(2 * i + 1), 1'b0, 3'd3);
    drain();
    chk(obs_coef.size() == 4, "post_reset_count", obs_coef.size(), 4);
    for (int i = 0; i < obs_coef.size(); i++) chk(obs_coef[i] == RAMP[i], "post_reset_coef", obs_coef[i], RAMP[i]);
    if (obs_cyc.size() == 4) chk(obs_cyc[0] == t_in + 3, "post_reset_latency", obs_cyc[0] - t_in, 3);

    // 7: random lines with gaps, partial lines and aborts
    for (int ln = 0; ln < 40; ln++) begin
      logic            m;
      logic [RC_W-1:0] rc;
      int              np;
      m  = 1'($urandom_range(0, 1));
      rc = 3'($urandom_range(0, 7));
      np = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : LR;
      for (int j = 0; j < np; j++) begin
        send_pair(rpix(), rpix(), m, rc);
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      end
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dwt53_mac.md
# dwt53_mac

Single-clock 5/3 lifting engine between `image_buffer`'s pixel-pair output and its coefficient-pair input.
- Consumes one even/odd pixel pair per cycle, row-wise or column-wise.
- Applies the reversible LeGall 5/3 predict/update with symmetric extension at line ends.
- Returns one {approx, detail} pair per input pair, in line order, tagged with the same mode and row/column index.

## Interface
- `WIDTH`, 512, image width in pixels (even, ≥4)
- `HEIGHT`, 512, image height in pixels (even, ≥4)
- `RC_W`, $clog2(WIDTH), row/column index width
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-low reset; clears all state while low
- `i_pix`  in  16  [15:8] even pixel, [7:0] odd pixel, unsigned
- `i_pix_valid`  in  1  pair present this cycle
- `i_pix_mode`  in  1  0 = row line (WIDTH px), 1 = column line (HEIGHT px)
- `i_pix_row_column`  in  RC_W  line index
- `o_coef`  out  16  [15:8] approx a, [7:0] detail d+128, both saturated 0..255
- `o_coef_valid`  out  1  coefficient pair valid
- `o_coef_mode`  out  1  mode of emitted pair
- `o_coef_row_column`  out  RC_W  line index of emitted pair
- `o_line_done`  out  1  one-cycle pulse with the last pair of a line
- `o_err`  out  1  one-cycle pulse on line abort

## Operation
- Line length in pairs: L = WIDTH/2 (mode 0) or HEIGHT/2 (mode 1).
- Pair counter k runs 0..L-1 and wraps to 0 after L-1.
- Pair k is (e_k, o_k). Its outputs need e_{k+1}, which comes from the next pair.
  - Symmetric extension at the line end: e_L = e_{L-1}.
- Predict: d_k = o_k − ((e_k + e_{k+1}) >> 1), signed 10-bit.
- Update: a_k = e_k + ((d_{k−1} + d_k + 2) >>> 2), arithmetic shift, signed 11-bit.
  - Boundary: d_{−1} = d_0.
- Output formatting:
  - `o_coef[15:8]` = clamp(a_k, 0, 255).
  - `o_coef[7:0]` = clamp(d_k + 128, 0, 255).
- Pipeline:
  - Holding register H keeps the current pair and its tags.
  - Stage P computes d and keeps d_{k−1}.
  - Stage U computes a, saturates, and drives the outputs.
- Sampling pair k ≥ 1 releases pair k−1 into P.
- Sampling pair L−1 also sets a flush flag. Next cycle, pair L−1 enters P with the extended e, whatever `i_pix_valid` is.
  - Pair 0 of the next line arriving that same cycle is only loaded into H. There is no conflict.
- Abort: a valid pair with k ≠ 0 whose mode or row_column differs from H's tags.
  - Discard H and the d history.
  - Pulse `o_err`.
  - Treat the new pair as k = 0 of its line.
  - Pairs already in P/U still complete normally.
- `i_pix_valid` low: nothing advances except a pending flush. Gaps inside a line are legal.
- Reset values:
  - All outputs 0; `o_coef_valid`, `o_line_done`, `o_err` = 0.
  - k = 0, flush = 0, H/P empty.

## Timing
- Pair k < L−1 appears on `o_coef` 2 cycles after pair k+1 is sampled.
- Pair L−1 appears 3 cycles after it is sampled, with `o_line_done` = 1.
- With continuous input, output is continuous. Each line yields exactly L valid cycles, in order, with no bubbles between lines.
- `o_coef_mode` / `o_coef_row_column` are aligned with `o_coef_valid`.
- `o_err` asserts the cycle after the offending pair is sampled.
- Reset low mid-line: everything clears immediately; in-flight pairs are lost. After release, the first valid pair is k = 0.

## Structure
- Shared package `dwt_pkg`:
  - WIDTH, HEIGHT, PIX_W = 8, D_W = 10, A_W = 11, DC_OFFSET = 128.
  - Enum line_mode_t {ROW = 0, COL = 1}.
  - Function clamp_u8 (signed → 8-bit unsigned).
- One sub-module, `dwt53_line_ctrl`:
  - Pair counter, L selection by mode, abort detection, flush flag, `o_line_done` generation.
- Datapath (H, P, U) stays in `dwt53_mac`.

## Test plan
- Set WIDTH = HEIGHT = 8, reset, then send a mode-0 row-3 ramp of pairs (0,1),(2,3),(4,5),(6,7) back-to-back.
  - Required: `o_coef` = 0x0080, 0x0280, 0x0480, 0x0681 with row_column = 3.
  - `o_line_done` with the last pair; first output 3 cycles after the first input.
- Constant line of all pixels 50 in mode 1 → every output 0x3280, 4 valid per line.
- Two consecutive rows streamed without a gap → 8 contiguous valid outputs; second row's tags switch exactly at its first output.
- Pairs (0,255),(0,255),(0,255),(0,255) → d = 255 saturates to 0xFF; a clamps to ≤255. Check no wrap.
- Row 1 sends 2 pairs, then a row-2 pair arrives → `o_err` pulse; row 2 then outputs 4 correct pairs; row 1 emits only its already-released pair 0.
- Assert `rst` low for 1 cycle mid-line → all outputs 0 immediately; a fresh ramp afterwards reproduces scenario 1 exactly.
